// File: rtl/data_memory.sv
// data_memory: data-memory responder for the load/store interface driven by
// memory_access.
//
// Writes are synchronous. Reads are registered with one cycle of latency, and
// a write and a read to the same index on the same edge return the new data.
// After every reset a state machine zero-fills the whole storage, one word per
// clock. memory_ready stays low until the fill is done, and writes are ignored
// until then. A write whose address lies outside the implemented storage is
// dropped and flagged on memory_address_error for one cycle.
//
// Ports:
//   clk                   clock; all state updates on the rising edge
//   rst_n                 asynchronous active-low reset
//   memory_read_address   word address to read (ADDR_WIDTH)
//   memory_read_data      registered read data (DATA_WIDTH)
//   memory_write_address  word address to write (ADDR_WIDTH)
//   memory_write_data     write data (DATA_WIDTH)
//   memory_write_enable   write strobe
//   memory_ready          high once the zero-fill is complete
//   memory_address_error  one-cycle flag after a rejected out-of-range write
//   memory_write_count    (only with DATA_MEMORY_WRITE_COUNTER_EN) saturating
//                         32-bit count of accepted writes
//
// Optional feature macro: DATA_MEMORY_WRITE_COUNTER_EN

`ifndef MEMORY_DEPTH
`define MEMORY_DEPTH 32
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif

module data_memory #(
  parameter int ADDR_WIDTH  = `MEMORY_DEPTH,
  parameter int DATA_WIDTH  = `MEMORY_WIDTH,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] memory_read_address,
  output logic [DATA_WIDTH-1:0] memory_read_data,
  input  logic [ADDR_WIDTH-1:0] memory_write_address,
  input  logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic                  memory_write_enable,
  output logic                  memory_ready,
  output logic                  memory_address_error
`ifdef DATA_MEMORY_WRITE_COUNTER_EN
  ,
  output logic [31:0]           memory_write_count
`endif
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = 1;
  localparam logic [INDEX_WIDTH-1:0] IDX_LAST = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] clear_idx_q, clear_idx_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   addr_err_q, addr_err_d;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   wr_in_range, rd_in_range;
  logic [INDEX_WIDTH-1:0] wr_idx, rd_idx;
  logic                   wr_accept;
  logic                   mem_we;
  logic [INDEX_WIDTH-1:0] mem_widx;
  logic [DATA_WIDTH-1:0]  mem_wdata;

  assign wr_idx = memory_write_address[INDEX_WIDTH-1:0];
  assign rd_idx = memory_read_address[INDEX_WIDTH-1:0];

  // An address is in range only when every bit above the index is zero.
  // With no such bits the whole address space is implemented.
  if (ADDR_WIDTH > INDEX_WIDTH) begin : g_range_chk
    assign wr_in_range = (memory_write_address[ADDR_WIDTH-1:INDEX_WIDTH] == '0);
    assign rd_in_range = (memory_read_address[ADDR_WIDTH-1:INDEX_WIDTH] == '0);
  end else begin : g_full_range
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    rd_data_d   = '0;
    addr_err_d  = 1'b0;
    wr_accept   = 1'b0;
    mem_we      = 1'b0;
    mem_widx    = clear_idx_q;
    mem_wdata   = '0;

    if (state_q == ST_CLEAR) begin
      // The fill port owns the storage. Read data and the error flag stay 0.
      mem_we      = 1'b1;
      clear_idx_d = clear_idx_q + IDX_ONE;
      if (clear_idx_q == IDX_LAST) begin
        state_d = ST_READY;
      end
    end else begin
      if (memory_write_enable) begin
        if (wr_in_range) begin
          wr_accept = 1'b1;
          mem_we    = 1'b1;
          mem_widx  = wr_idx;
          mem_wdata = memory_write_data;
        end else begin
          addr_err_d = 1'b1;
        end
      end
      // Write-first: a same-edge write to the read index bypasses the array.
      if (rd_in_range) begin
        if (wr_accept && (wr_idx == rd_idx)) begin
          rd_data_d = memory_write_data;
        end else begin
          rd_data_d = mem[rd_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clear_idx_q <= '0;
      rd_data_q   <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      rd_data_q   <= rd_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Storage has no reset. The CLEAR pass initialises it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  assign memory_read_data     = rd_data_q;
  assign memory_address_error = addr_err_q;
  assign memory_ready         = (state_q == ST_READY);

`ifdef DATA_MEMORY_WRITE_COUNTER_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_accept && (wr_cnt_q != 32'hFFFF_FFFF)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign memory_write_count = wr_cnt_q;
`endif

endmodule
